// File: rtl/agc_mem_pkg.sv
// Shared types and helpers for the AGC memory arbiter: FSM states,
// counter direction encodings and the ones-complement step function.
package agc_mem_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CNT_RD  = 2'd1,
    CNT_MOD = 2'd2,
    CNT_WR  = 2'd3
  } arb_state_e;

  localparam logic CNT_PINC = 1'b0;
  localparam logic CNT_MINC = 1'b1;

  // Widest counter the step function handles (w must stay below this).
  localparam int unsigned OC_MAX_W = 64;

  // Ones-complement +1 / -1 on a w-bit value with end-around carry.
  // -1 is formed by adding the ones-complement of 1 (all ones except bit 0).
  function automatic logic [OC_MAX_W-1:0] oc_step(input logic [OC_MAX_W-1:0] v,
                                                  input logic                dir,
                                                  input int unsigned         w);
    logic [OC_MAX_W-1:0] mask;
    logic [OC_MAX_W-1:0] addend;
    logic [OC_MAX_W-1:0] sum;
    logic [OC_MAX_W-1:0] carry;
    mask   = (OC_MAX_W'(1) << w) - OC_MAX_W'(1);
    addend = OC_MAX_W'(1);
    case (dir)
      CNT_PINC: addend = OC_MAX_W'(1);
      CNT_MINC: addend = mask ^ OC_MAX_W'(1);
    endcase
    sum   = (v & mask) + addend;
    carry = (sum >> w) & OC_MAX_W'(1);
    return ((sum & mask) + carry) & mask;
  endfunction

endpackage

// File: rtl/agc_cnt_fifo.sv
// Pending-increment queue: synchronous FIFO of {dir, addr} entries with
// full/empty flags. Pointers carry one extra wrap bit to tell full from empty.
module agc_cnt_fifo #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              push_dir,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic              pop,
  output logic              head_dir,
  output logic [ADDR_W-1:0] head_addr,
  output logic              full,
  output logic              empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned ENT_W = ADDR_W + 1;

  logic [ENT_W-1:0] store_q [DEPTH];
  logic [PTR_W:0]   wr_ptr_q;
  logic [PTR_W:0]   rd_ptr_q;

  // Pointer update and entry storage; reset only discards by clearing pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) begin
        store_q[wr_ptr_q[PTR_W-1:0]] <= {push_dir, push_addr};
        wr_ptr_q <= wr_ptr_q + (PTR_W + 1)'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + (PTR_W + 1)'(1);
      end
    end
  end

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                 (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign {head_dir, head_addr} = store_q[rd_ptr_q[PTR_W-1:0]];

endmodule

// File: rtl/agc_mem_arbiter.sv
// Single-port AGC memory arbiter: the CPU owns the port by default, queued
// PINC/MINC counter increments steal it for a read-modify-write sequence
// when the CPU is idle, the queue is full, or the queue has waited too long.
// Optional feature macro: AGC_CNT_OVF_EN adds ovf_pulse/ovf_addr outputs
// flagging ones-complement overflow of a counter.
module agc_mem_arbiter
  import agc_mem_pkg::*;
#(
  parameter int unsigned ADDR_W       = 12,
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned CNT_DEPTH    = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_valid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              cnt_req,
  input  logic              cnt_dir,
  input  logic [ADDR_W-1:0] cnt_addr,
  output logic              cnt_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
`ifdef AGC_CNT_OVF_EN
  output logic              ovf_pulse,
  output logic [ADDR_W-1:0] ovf_addr,
`endif
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

  arb_state_e          state_q;
  logic [STARVE_W-1:0] starve_q;
  logic                rd_pend_q;
  logic [ADDR_W-1:0]   cnt_addr_q;
  logic                cnt_dir_q;
  logic [DATA_W-1:0]   rd_q;
  logic [DATA_W-1:0]   res_q;

  logic                fifo_full;
  logic                fifo_empty;
  logic                head_dir;
  logic [ADDR_W-1:0]   head_addr;
  logic                push_c;
  logic                steal_c;

  agc_cnt_fifo #(
    .ADDR_W (ADDR_W),
    .DEPTH  (CNT_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_c),
    .push_dir  (cnt_dir),
    .push_addr (cnt_addr),
    .pop       (steal_c),
    .head_dir  (head_dir),
    .head_addr (head_addr),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Queue acceptance and IDLE arbitration; counters win only when the CPU
  // is idle, the queue is full, or the queue has been starved.
  assign cnt_ready = !rst && !fifo_full;
  assign push_c    = cnt_req && cnt_ready;
  assign steal_c   = !rst && (state_q == IDLE) && !fifo_empty &&
                     (fifo_full || (starve_q >= STARVE_W'(STARVE_LIMIT)) || !cpu_req);
  assign cpu_gnt   = !rst && (state_q == IDLE) && cpu_req && !steal_c;
  assign cpu_valid = rd_pend_q && !rst;
  assign cpu_rdata = cpu_valid ? mem_rdata : '0;

  // Memory port mux; reset forces an idle port so no partial write escapes.
  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (steal_c) begin
            mem_addr = head_addr;
          end else if (cpu_gnt) begin
            mem_addr  = cpu_addr;
            mem_we    = cpu_we;
            mem_wdata = cpu_wdata;
          end
        end
        CNT_RD, CNT_MOD: mem_addr = cnt_addr_q;
        CNT_WR: begin
          mem_addr  = cnt_addr_q;
          mem_we    = 1'b1;
          mem_wdata = res_q;
        end
        default: ;
      endcase
    end
  end

  // RMW sequencer, starve counter and CPU read-valid pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      starve_q   <= '0;
      rd_pend_q  <= 1'b0;
      cnt_addr_q <= '0;
      cnt_dir_q  <= CNT_PINC;
      rd_q       <= '0;
      res_q      <= '0;
    end else begin
      rd_pend_q <= cpu_gnt && !cpu_we;
      case (state_q)
        IDLE: begin
          if (steal_c) begin
            state_q    <= CNT_RD;
            cnt_addr_q <= head_addr;
            cnt_dir_q  <= head_dir;
            starve_q   <= '0;
          end else if (cpu_gnt && !fifo_empty &&
                       (starve_q < STARVE_W'(STARVE_LIMIT))) begin
            starve_q <= starve_q + STARVE_W'(1);
          end
        end
        CNT_RD: begin
          rd_q    <= mem_rdata;
          state_q <= CNT_MOD;
        end
        CNT_MOD: begin
          res_q   <= DATA_W'(oc_step(OC_MAX_W'(rd_q), cnt_dir_q, DATA_W));
          state_q <= CNT_WR;
        end
        CNT_WR:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef AGC_CNT_OVF_EN
  localparam logic [DATA_W-1:0] POS_MAX = {1'b0, {(DATA_W - 1){1'b1}}};
  localparam logic [DATA_W-1:0] NEG_MAX = {1'b1, {(DATA_W - 1){1'b0}}};

  logic              ovf_q;
  logic [ADDR_W-1:0] ovf_addr_q;

  // Flag overflow while computing the result so the pulse lines up with CNT_WR.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q      <= 1'b0;
      ovf_addr_q <= '0;
    end else begin
      ovf_q <= 1'b0;
      if ((state_q == CNT_MOD) &&
          (((cnt_dir_q == CNT_PINC) && (rd_q == POS_MAX)) ||
           ((cnt_dir_q == CNT_MINC) && (rd_q == NEG_MAX)))) begin
        ovf_q      <= 1'b1;
        ovf_addr_q <= cnt_addr_q;
      end
    end
  end

  assign ovf_pulse = ovf_q && !rst;
  assign ovf_addr  = ovf_addr_q;
`endif

endmodule

// File: tb/tb_agc_mem_arbiter.sv
// Directed bench for agc_mem_arbiter with a behavioural synchronous memory,
// a write scoreboard and a CPU read-data scoreboard.
module tb_agc_mem_arbiter;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DATA_W = 16;

  logic              clk;
  logic              rst;
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_valid;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cnt_req;
  logic              cnt_dir;
  logic [ADDR_W-1:0] cnt_addr;
  logic              cnt_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
`ifdef AGC_CNT_OVF_EN
  logic              ovf_pulse;
  logic [ADDR_W-1:0] ovf_addr;
`endif

  logic [DATA_W-1:0] mem [4096];
  logic              bk_we;
  logic [ADDR_W-1:0] bk_addr;
  logic [DATA_W-1:0] bk_data;

  int unsigned n_vec;
  int unsigned n_err;
  logic [31:0] wq [$];
  logic [31:0] rq [$];

  logic [ADDR_W-1:0] f_addr [4];
  logic              f_dir  [4];
  logic [DATA_W-1:0] f_exp  [4];

  agc_mem_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_gnt   (cpu_gnt),
    .cpu_valid (cpu_valid),
    .cpu_rdata (cpu_rdata),
    .cnt_req   (cnt_req),
    .cnt_dir   (cnt_dir),
    .cnt_addr  (cnt_addr),
    .cnt_ready (cnt_ready),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
`ifdef AGC_CNT_OVF_EN
    .ovf_pulse (ovf_pulse),
    .ovf_addr  (ovf_addr),
`endif
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous single-port memory with a backdoor preload port.
  always @(posedge clk) begin
    if (mem_we === 1'b1) mem[mem_addr] <= mem_wdata;
    else if (bk_we) mem[bk_addr] <= bk_data;
    mem_rdata <= mem[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Every memory write must match the next expected write, in order.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      n_vec++;
      assert (wq.size() > 0) else begin
        n_err++;
        $error("FAIL write_unexpected: observed addr %h data %h expected no write", mem_addr, mem_wdata);
      end
      if (wq.size() > 0) check("mem_write", 32'({mem_addr, mem_wdata}), wq.pop_front());
    end
    if (cpu_valid === 1'b1) begin
      n_vec++;
      assert (rq.size() > 0) else begin
        n_err++;
        $error("FAIL valid_unexpected: observed data %h expected no valid", cpu_rdata);
      end
      if (rq.size() > 0) check("cpu_rdata", 32'(cpu_rdata), rq.pop_front());
    end
  end

  task automatic drive_slot();
    @(posedge clk);
    #1;
  endtask

  task automatic probe();
    @(negedge clk);
  endtask

  task automatic bk_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    drive_slot();
    bk_we = 1'b1;
    bk_addr = a;
    bk_data = d;
  endtask

  function automatic logic [DATA_W-1:0] rdat(input int unsigned i);
    return 16'hA5A0 | DATA_W'(i);
  endfunction

  // One queued increment with the CPU idle: steal, RD, MOD, WR, back to IDLE.
  task automatic do_inc(input logic [ADDR_W-1:0] a, input logic d, input logic [DATA_W-1:0] e);
    drive_slot();
    cnt_req = 1'b1; cnt_dir = d; cnt_addr = a;
    wq.push_back(32'({a, e}));
    probe();
    check("inc_ready", 32'(cnt_ready), 32'd1);
    drive_slot();
    cnt_req = 1'b0;
    probe();
    check("steal_addr", 32'(mem_addr), 32'(a));
    check("steal_gnt", 32'(cpu_gnt), 32'd0);
    check("steal_we", 32'(mem_we), 32'd0);
    drive_slot(); probe();
    check("rd_we", 32'(mem_we), 32'd0);
    drive_slot(); probe();
    check("mod_we", 32'(mem_we), 32'd0);
    drive_slot(); probe();
    check("wr_we", 32'(mem_we), 32'd1);
    check("wr_addr", 32'(mem_addr), 32'(a));
`ifdef AGC_CNT_OVF_EN
    check("ovf_pulse", 32'(ovf_pulse),
          32'(((d == 1'b0) && (e == 16'h8000)) || ((d == 1'b1) && (e == 16'h7FFF))));
    if (((d == 1'b0) && (e == 16'h8000)) || ((d == 1'b1) && (e == 16'h7FFF)))
      check("ovf_addr", 32'(ovf_addr), 32'(a));
`endif
    drive_slot(); probe();
    check("post_wr_we", 32'(mem_we), 32'd0);
`ifdef AGC_CNT_OVF_EN
    check("ovf_single", 32'(ovf_pulse), 32'd0);
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_vec = 0; n_err = 0;
    rst = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h123; cpu_wdata = 16'h5555;
    cnt_req = 1'b1; cnt_dir = 1'b0; cnt_addr = 12'h024;
    bk_we = 1'b0; bk_addr = '0; bk_data = '0;
    f_addr[0] = 12'h050; f_dir[0] = 1'b0; f_exp[0] = 16'h0002;
    f_addr[1] = 12'h051; f_dir[1] = 1'b1; f_exp[1] = 16'h0001;
    f_addr[2] = 12'h050; f_dir[2] = 1'b0; f_exp[2] = 16'h0003;
    f_addr[3] = 12'h052; f_dir[3] = 1'b0; f_exp[3] = 16'h0001;

    // Reset values with requests pending.
    drive_slot(); probe();
    check("rst_cpu_gnt", 32'(cpu_gnt), 32'd0);
    check("rst_cpu_valid", 32'(cpu_valid), 32'd0);
    check("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst_cnt_ready", 32'(cnt_ready), 32'd0);

    // Preload memory while held in reset.
    bk_write(12'h024, 16'h0005);
    bk_write(12'h030, 16'h0000);
    bk_write(12'h031, 16'hFFFF);
    bk_write(12'h032, 16'h7FFF);
    bk_write(12'h033, 16'h8000);
    bk_write(12'h040, 16'h0010);
    bk_write(12'h050, 16'h0001);
    bk_write(12'h051, 16'h0002);
    bk_write(12'h052, 16'hFFFF);
    bk_write(12'h060, 16'h1234);
    bk_write(12'h061, 16'h0042);
    for (int i = 0; i < 4; i++) bk_write(12'h100 + ADDR_W'(i), rdat(i));

    drive_slot();
    bk_we = 1'b0; rst = 1'b0; cpu_req = 1'b0; cnt_req = 1'b0;
    probe();
    check("post_rst_ready", 32'(cnt_ready), 32'd1);
    check("post_rst_gnt", 32'(cpu_gnt), 32'd0);
    check("post_rst_we", 32'(mem_we), 32'd0);

    // Counter RMWs with the CPU idle, including ones-complement edge values.
    do_inc(12'h024, 1'b0, 16'h0006);
    do_inc(12'h030, 1'b1, 16'hFFFE);
    do_inc(12'h031, 1'b0, 16'h0001);
    do_inc(12'h032, 1'b0, 16'h8000);
    do_inc(12'h033, 1'b1, 16'h7FFF);

    // CPU write, then back-to-back reads.
    drive_slot();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h110; cpu_wdata = 16'hBEEF;
    wq.push_back(32'({12'h110, 16'hBEEF}));
    probe();
    check("cpu_wr_gnt", 32'(cpu_gnt), 32'd1);
    check("cpu_wr_we", 32'(mem_we), 32'd1);
    for (int i = 0; i < 4; i++) begin
      drive_slot();
      cpu_we = 1'b0; cpu_addr = 12'h100 + ADDR_W'(i);
      rq.push_back(32'(rdat(i)));
      probe();
      check("cpu_rd_gnt", 32'(cpu_gnt), 32'd1);
      check("cpu_rd_addr", 32'(mem_addr), 32'(12'h100 + ADDR_W'(i)));
      check("cpu_rd_valid", 32'(cpu_valid), 32'(i > 0));
    end
    drive_slot();
    cpu_addr = 12'h110;
    rq.push_back(32'(16'hBEEF));
    probe();
    check("cpu_rd_valid", 32'(cpu_valid), 32'd1);
    drive_slot();
    cpu_req = 1'b0;
    probe();
    check("cpu_rd_valid", 32'(cpu_valid), 32'd1);
    drive_slot(); probe();
    check("cpu_rd_valid_end", 32'(cpu_valid), 32'd0);

    // Starvation: one queued PINC while the CPU keeps requesting.
    drive_slot();
    cnt_req = 1'b1; cnt_dir = 1'b0; cnt_addr = 12'h040;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h100;
    wq.push_back(32'({12'h040, 16'h0011}));
    rq.push_back(32'(rdat(0)));
    probe();
    check("starve_gnt0", 32'(cpu_gnt), 32'd1);
    for (int i = 1; i <= 8; i++) begin
      drive_slot();
      cnt_req = 1'b0;
      rq.push_back(32'(rdat(0)));
      probe();
      check("starve_gnt", 32'(cpu_gnt), 32'd1);
    end
    drive_slot(); probe();
    check("starve_steal_gnt", 32'(cpu_gnt), 32'd0);
    check("starve_steal_addr", 32'(mem_addr), 32'(12'h040));
    for (int i = 0; i < 3; i++) begin
      drive_slot(); probe();
      check("starve_blocked", 32'(cpu_gnt), 32'd0);
    end
    drive_slot();
    rq.push_back(32'(rdat(0)));
    probe();
    check("starve_regrant", 32'(cpu_gnt), 32'd1);
    drive_slot();
    cpu_req = 1'b0;
    probe();

    // Fill the queue under CPU load: full forces an immediate steal.
    for (int i = 0; i < 4; i++) begin
      drive_slot();
      cnt_req = 1'b1; cnt_dir = f_dir[i]; cnt_addr = f_addr[i];
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h100;
      wq.push_back(32'({f_addr[i], f_exp[i]}));
      rq.push_back(32'(rdat(0)));
      probe();
      check("fill_ready", 32'(cnt_ready), 32'd1);
      check("fill_gnt", 32'(cpu_gnt), 32'd1);
    end
    drive_slot();
    cnt_addr = 12'h054; cnt_dir = 1'b0;
    probe();
    check("full_ready", 32'(cnt_ready), 32'd0);
    check("full_steal_gnt", 32'(cpu_gnt), 32'd0);
    check("full_steal_addr", 32'(mem_addr), 32'(12'h050));
    drive_slot();
    cnt_req = 1'b0; cpu_req = 1'b0;
    probe();
    repeat (20) begin drive_slot(); probe(); end
    check("drain_ready", 32'(cnt_ready), 32'd1);

    // Reset during CNT_WR: no write, queue discarded.
    drive_slot();
    cnt_req = 1'b1; cnt_dir = 1'b0; cnt_addr = 12'h060;
    probe();
    check("rstwr_push_ready", 32'(cnt_ready), 32'd1);
    drive_slot();
    cnt_addr = 12'h061;
    probe();
    check("rstwr_steal_addr", 32'(mem_addr), 32'(12'h060));
    drive_slot(); cnt_req = 1'b0; probe();
    drive_slot(); probe();
    drive_slot();
    rst = 1'b1;
    probe();
    check("rstwr_we", 32'(mem_we), 32'd0);
    check("rstwr_ready", 32'(cnt_ready), 32'd0);
    drive_slot();
    rst = 1'b0;
    probe();
    check("rstwr_ready_after", 32'(cnt_ready), 32'd1);
    for (int i = 0; i < 6; i++) begin
      drive_slot(); probe();
      check("rstwr_no_rmw", 32'(mem_we), 32'd0);
    end
    check("rstwr_mem_060", 32'(mem[12'h060]), 32'(16'h1234));
    check("rstwr_mem_061", 32'(mem[12'h061]), 32'(16'h0042));

    check("wq_drained", 32'(wq.size()), 32'd0);
    check("rq_drained", 32'(rq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
